// File: rtl/shift_unit_pkg.sv
// Shared opcode encoding and default widths for the shift unit.
package shift_unit_pkg;

  localparam int IN_WIDTH_DEF  = 8;
  localparam int OUT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    SHR_A = 2'b00,
    SHL_A = 2'b01,
    SHR_B = 2'b10,
    SHL_B = 2'b11
  } alu_fun_e;

endpackage

// File: rtl/shift_unit_core.sv
// Combinational shifter: selects A or B, shifts by one, zero-extends to OUT_WIDTH.
module shift_unit_core
  import shift_unit_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic [1:0]           alu_fun,
  output logic [OUT_WIDTH-1:0] result
);

  // One spare MSB so a left shift keeps the carried-out bit.
  logic [IN_WIDTH:0] a_ext;
  logic [IN_WIDTH:0] b_ext;
  logic [IN_WIDTH:0] shifted;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    shifted = '0;
    result  = '0;
    case (alu_fun)
      SHR_A:   shifted = a_ext >> 1;
      SHL_A:   shifted = a_ext << 1;
      SHR_B:   shifted = b_ext >> 1;
      SHL_B:   shifted = b_ext << 1;
      default: shifted = '0;
    endcase
    result[IN_WIDTH:0] = shifted;
  end

endmodule

// File: rtl/shift_unit.sv
// Registered one-cycle shift unit. Define SHIFT_UNIT_HOLD_EN to keep SHIFT_OUT
// while Shift_Enable is low; by default SHIFT_OUT clears to zero.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [1:0]           ALU_FUN,
  input  logic                 Shift_Enable,
  output logic [OUT_WIDTH-1:0] SHIFT_OUT,
  output logic                 SHIFT_Flag
);

  logic [OUT_WIDTH-1:0] result;

  shift_unit_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .a       (A),
    .b       (B),
    .alu_fun (ALU_FUN),
    .result  (result)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (RST) begin
      SHIFT_OUT  <= '0;
      SHIFT_Flag <= 1'b0;
    end else if (Shift_Enable) begin
      SHIFT_OUT  <= result;
      SHIFT_Flag <= 1'b1;
    end else begin
      SHIFT_Flag <= 1'b0;
`ifdef SHIFT_UNIT_HOLD_EN
      SHIFT_OUT  <= SHIFT_OUT;
`else
      SHIFT_OUT  <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, mid-cycle
// stability sequence and randomized traffic against an arithmetic model.
module tb_shift_unit;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;

`ifdef SHIFT_UNIT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic [1:0]       alu_fun;
  logic             shift_enable;
  logic [OUT_W-1:0] shift_out;
  logic             shift_flag;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the outputs should be after the most recent edge.
  int model_out  = 0;
  int model_flag = 0;

  always #5 clk = ~clk;

  shift_unit #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk          (clk),
    .RST          (rst),
    .A            (a),
    .B            (b),
    .ALU_FUN      (alu_fun),
    .Shift_Enable (shift_enable),
    .SHIFT_OUT    (shift_out),
    .SHIFT_Flag   (shift_flag)
  );

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] fun;
    int       a;
    int       b;
    int       exp_out;
    int       exp_flag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  // Operation semantics written as plain arithmetic on unsigned integers.
  function automatic int ref_shift(input bit [1:0] fun, input int op_a, input int op_b);
    case (fun)
      2'd0:    return op_a / 2;
      2'd1:    return op_a * 2;
      2'd2:    return op_b / 2;
      default: return op_b * 2;
    endcase
  endfunction

  function automatic void model_edge(input bit r, input bit en, input bit [1:0] fun,
                                     input int op_a, input int op_b);
    if (r) begin
      model_out  = 0;
      model_flag = 0;
    end else if (en) begin
      model_out  = ref_shift(fun, op_a, op_b);
      model_flag = 1;
    end else begin
      model_flag = 0;
      if (!HOLD) model_out = 0;
    end
  endfunction

  // Drive inputs, take one rising edge, then settle 1ns before sampling.
  task automatic step(input bit r, input bit en, input bit [1:0] fun,
                      input int op_a, input int op_b);
    rst          = r;
    shift_enable = en;
    alu_fun      = fun;
    a            = op_a[IN_W-1:0];
    b            = op_b[IN_W-1:0];
    @(posedge clk);
    #1;
    model_edge(r, en, fun, op_a, op_b);
  endtask

  initial begin
    rst = 1'b0; shift_enable = 1'b0; alu_fun = 2'd0; a = '0; b = '0;

    //                rst en  fun   a    b    out                   flag
    vecs.push_back('{1, 0, 2'd0,   0,   0,   0,                    0});
    vecs.push_back('{0, 1, 2'd0,  40,   0,   20,                   1});
    vecs.push_back('{0, 1, 2'd1,  50,   0,   100,                  1});
    vecs.push_back('{0, 1, 2'd1, 255,   0,   'h1FE,                1});
    vecs.push_back('{0, 1, 2'd2,   0,  80,   40,                   1});
    vecs.push_back('{0, 1, 2'd3,   0,   5,   10,                   1});
    vecs.push_back('{0, 1, 2'd3,   0, 255,   'h1FE,                1});
    vecs.push_back('{0, 1, 2'd0, 255,   0,   'h07F,                1});
    vecs.push_back('{1, 1, 2'd2,   0,  15,   0,                    0});
    vecs.push_back('{0, 1, 2'd0,  40,   0,   20,                   1});
    vecs.push_back('{0, 0, 2'd1,  99,  99,   HOLD ? 20 : 0,        0});
    vecs.push_back('{0, 0, 2'd3,   7,   7,   HOLD ? 20 : 0,        0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].fun, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_out", i), int'(shift_out), vecs[i].exp_out);
      check($sformatf("vec%0d_flag", i), int'(shift_flag), vecs[i].exp_flag);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    step(0, 1, 2'd1, 50, 0);
    check("stable_pre_out", int'(shift_out), 100);
    a = 8'd7; b = 8'd90; alu_fun = 2'd2; shift_enable = 1'b0;
    #3;
    check("stable_mid_out", int'(shift_out), 100);
    check("stable_mid_flag", int'(shift_flag), 1);
    shift_enable = 1'b1;
    @(posedge clk);
    #1;
    model_edge(0, 1, 2'd2, 7, 90);
    check("stable_post_out", int'(shift_out), 45);

    // After reset, a result appears exactly one edge after enable is sampled.
    step(1, 0, 2'd0, 0, 0);
    check("post_rst_out", int'(shift_out), 0);
    step(0, 0, 2'd1, 3, 0);
    check("idle_flag", int'(shift_flag), 0);
    check("idle_out", int'(shift_out), 0);
    step(0, 1, 2'd1, 3, 0);
    check("first_flag", int'(shift_flag), 1);
    check("first_out", int'(shift_out), 6);

    // Randomized traffic against the model.
    step(1, 0, 2'd0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      bit       r;
      bit       en;
      bit [1:0] fun;
      int       ra;
      int       rb;
      r   = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      fun = 2'($urandom_range(0, 3));
      ra  = int'($urandom_range(0, 255));
      rb  = int'($urandom_range(0, 255));
      step(r, en, fun, ra, rb);
      check($sformatf("rnd%0d_out", i), int'(shift_out), model_out);
      check($sformatf("rnd%0d_flag", i), int'(shift_flag), model_flag);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001: Parameter IN_WIDTH, default 8, width of operands A and B.
REQ-002: Parameter OUT_WIDTH, default 16, width of SHIFT_OUT; SHALL satisfy OUT_WIDTH >= IN_WIDTH+1.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: RST  input  1  reset, synchronous and active-high.
REQ-005: A  input  IN_WIDTH  operand A, unsigned.
REQ-006: B  input  IN_WIDTH  operand B, unsigned.
REQ-007: ALU_FUN  input  2  operation select.
REQ-008: Shift_Enable  input  1  enables the shift unit for this cycle.
REQ-009: SHIFT_OUT  output  OUT_WIDTH  registered shift result.
REQ-010: SHIFT_Flag  output  1  registered valid flag; high when SHIFT_OUT holds a result computed in the previous cycle.

Function
REQ-011: ALU_FUN=00 SHALL compute A >> 1 (logical, zero fill).
REQ-012: ALU_FUN=01 SHALL compute A << 1, keeping the carried-out MSB (IN_WIDTH+1 bits).
REQ-013: ALU_FUN=10 SHALL compute B >> 1 (logical, zero fill).
REQ-014: ALU_FUN=11 SHALL compute B << 1, keeping the carried-out MSB (IN_WIDTH+1 bits).
REQ-015: The result SHALL be zero-extended to OUT_WIDTH; no truncation or sign extension.
REQ-016: Latency SHALL be one cycle: inputs sampled at edge N appear on SHIFT_OUT/SHIFT_Flag after edge N.
REQ-017: With Shift_Enable=1 and RST=0 at an edge, SHIFT_OUT SHALL load the result and SHIFT_Flag SHALL be 1.
REQ-018: With Shift_Enable=0 and RST=0 at an edge, SHIFT_Flag SHALL be 0 and SHIFT_OUT SHALL follow REQ-024.
REQ-019: Operand or opcode changes between edges SHALL have no effect on the outputs until the next edge.
REQ-020: No handshake; a new operation SHALL be accepted every cycle Shift_Enable=1.

Reset
REQ-021: RST=1 at a rising edge SHALL set SHIFT_OUT to 0 and SHIFT_Flag to 0.
REQ-022: RST SHALL take priority over Shift_Enable and ALU_FUN in the same cycle.
REQ-023: After RST is deasserted, the first result SHALL appear one edge after Shift_Enable=1 is sampled.

Configuration
REQ-024: Macro SHIFT_UNIT_HOLD_EN: when defined, SHIFT_OUT SHALL hold its previous value while Shift_Enable=0; when undefined, SHIFT_OUT SHALL clear to 0 while Shift_Enable=0; SHIFT_Flag SHALL be 0 in both cases.

Structure
REQ-025: Package shift_unit_pkg SHALL hold the ALU_FUN opcode constants (SHR_A=00, SHL_A=01, SHR_B=10, SHL_B=11) and the default widths.
REQ-026: One combinational sub-module shift_unit_core (operands + opcode -> OUT_WIDTH result) SHALL be used; the top module holds only the output registers and the enable/reset logic.

Verification
REQ-027: RST=1 for one edge, then A=40, ALU_FUN=00, Shift_Enable=1 -> next edge SHIFT_OUT=20, SHIFT_Flag=1.
REQ-028: A=50, ALU_FUN=01 -> SHIFT_OUT=100, Flag=1; A=255, ALU_FUN=01 -> SHIFT_OUT=0x01FE.
REQ-029: B=80, ALU_FUN=10 -> SHIFT_OUT=40; B=5, ALU_FUN=11 -> SHIFT_OUT=10; B=255, ALU_FUN=11 -> SHIFT_OUT=0x01FE.
REQ-030: A=255, ALU_FUN=00 -> SHIFT_OUT=0x007F, Flag=1.
REQ-031: RST=1 with Shift_Enable=1 and B=15, ALU_FUN=10 -> SHIFT_OUT=0, Flag=0 (reset priority).
REQ-032: Result 20 loaded, then Shift_Enable=0 -> Flag=0; SHIFT_OUT=0 without SHIFT_UNIT_HOLD_EN, SHIFT_OUT=20 with it.
